add_seq_ctrl: RTL and testbench
===============================

Name: add_seq_ctrl

Overview:
- Multi-cycle sequencer for wide additions on one 4-bit adder slice (fa4-equivalent, a+b+ci on 4 bits).
- Accepts a WIDTH-bit operand pair through a valid/ready handshake and feeds one nibble per cycle, LSB nibble first, through the slice.
- Carry is registered between nibbles.
- Result is presented with a valid/ready output handshake.
- Sits between the operand source and any consumer needing wide sums without a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4.
- NIB (localparam), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- out_valid  output  1  s/co hold a completed result.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum.
- co  output  1  final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-high, sampled on rising edge of clk.
- Reset values:
  - state=IDLE, out_valid=0, busy=0, s=0, co=0.
  - in_ready=1 (combinational from state).
  - Nibble index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b; carry reg <= ci; index <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adds a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry.
  - Nibble result goes into working register bits [4i+3:4i]; carry <= slice carry-out; i <= i+1.
  - On the edge processing i=NIB-1: copy working register to s, final carry to co, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - On an edge with out_ready=1: go to IDLE and clear out_valid.
  - No bypass: a new operand is accepted no earlier than the edge after the result handshake.
- Latency: operands accepted at edge k -> out_valid high after edge k+NIB. Throughput is one result per NIB+2 cycles at best.
- s/co update only on the RUN->DONE transition. They hold the last result through DONE and IDLE. Partial nibbles are never visible on s.
- Arithmetic: {co,s} = (a + b + ci) mod 2^(WIDTH+1). Inputs are unsigned.
- in_valid while busy: ignored and not queued. Operand inputs change freely after acceptance.
- out_ready outside DONE: ignored.
- rst during RUN or DONE:
  - Operation aborted; next cycle is IDLE, out_valid=0, s=0, co=0.
  - No result is emitted.
- rst together with in_valid: reset wins; nothing is accepted.
- WIDTH=4: RUN lasts exactly one cycle.

Optional Feature:
- Macro ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands at acceptance.
  - sub=1 latches ~b and forces carry reg <= 1 (ci ignored), giving s = a - b mod 2^WIDTH.
  - co=1 means no borrow (a >= b).
  - sub=0 behaves as plain add.
- Not defined: no sub port; add only; logic identical to the base description.

Test Plan (WIDTH=16):
1. Reset and idle:
   - Stimulus: rst=1 for 2 cycles, then released with in_valid=0.
   - Response: in_ready=1, out_valid=0, busy=0, s=0x0000, co=0.
2. Basic add:
   - Stimulus: a=0x1234, b=0x4321, ci=0, accepted at edge k.
   - Response: out_valid rises after edge k+4; s=0x5555, co=0; busy high from k to the handshake.
3. Full carry ripple:
   - Stimulus: a=0xFFFF, b=0x0000, ci=1.
   - Response: s=0x0000, co=1. Also a=0x8000, b=0x8000, ci=0 -> s=0x0000, co=1.
4. Backpressure:
   - Stimulus: after a result, hold out_ready=0 for 5 cycles while in_valid=1 with a=0x0001, b=0x0001.
   - Response: out_valid stays 1, s/co stable, in_ready=0.
   - Then out_ready=1: IDLE next cycle, new op accepted, s=0x0002 four cycles later.
5. Reset mid-op:
   - Stimulus: assert rst on the 2nd RUN cycle of a=0x1111, b=0x2222.
   - Response: next cycle IDLE, out_valid=0, s=0, co=0; out_valid never rises for that op.
6. ADD_SEQ_SUB_EN defined:
   - Stimulus/response: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, co=0.
   - Stimulus/response: a=0x0007, b=0x0005, sub=1 -> s=0x0002, co=1.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: wide adder built from one 4-bit slice, one nibble per cycle, LSB first.
// Optional subtract mode when ADD_SEQ_SUB_EN is defined (adds the `sub` input port).
module add_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]   work_next;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W+1:0]   bit_base;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [4:0]         nib_sum;
    logic [WIDTH-1:0]   b_in;
    logic               carry_in;

`ifdef ADD_SEQ_SUB_EN
    // Two's-complement subtract: a + ~b + 1; co then reads as "no borrow".
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub ? 1'b1 : ci;
`else
    assign b_in     = b;
    assign carry_in = ci;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)        state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // The single 4-bit slice, fed by the nibble selected by idx.
    always_comb begin
        bit_base  = {idx, 2'b00};
        nib_a     = a_reg[bit_base +: 4];
        nib_b     = b_reg[bit_base +: 4];
        nib_sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        work_next = work_reg;
        work_next[bit_base +: 4] = nib_sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            work_reg <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            s        <= '0;
            co       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b_in;
                        carry <= carry_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    work_reg <= work_next;
                    carry    <= nib_sum[4];
                    idx      <= idx + IDX_W'(1);
                    // Publish only the complete word so partial sums never reach s.
                    if (idx == LAST_IDX) begin
                        s  <= work_next;
                        co <= nib_sum[4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl at WIDTH=16.
// Subtract vectors run only when ADD_SEQ_SUB_EN is defined.
module tb_add_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one operation, measure latency to out_valid, check result, then handshake.
    task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_ci, input logic op_sub,
                          input logic [15:0] exp_s, input logic exp_co);
        int lat;
        a = op_a; b = op_b; ci = op_ci; sub = op_sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~op_a; b = ~op_b; ci = ~op_ci;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        check({tag, "_co"}, 32'(co), 32'(exp_co));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
        check({tag, "_hold"}, 32'(s), 32'(exp_s));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s", 32'(s), 32'h0);
        check("rst_co", 32'(co), 32'd0);

        // Basic add with cycle-exact latency
        a = 16'h1234; b = 16'h4321; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_in_ready_run", 32'(in_ready), 32'd0);
        tick(); tick(); tick();
        check("add_not_yet_valid", 32'(out_valid), 32'd0);
        check("add_no_partial_s", 32'(s), 32'h0);
        tick();
        check("add_valid_k4", 32'(out_valid), 32'd1);
        check("add_s", 32'(s), 32'h5555);
        check("add_co", 32'(co), 32'd0);
        check("add_busy_done", 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("add_idle_busy", 32'(busy), 32'd0);

        // Carry ripple through every nibble
        run_op("ripple_ci", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        run_op("msb_carry", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        run_op("mixed",     16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

        // Backpressure: result held while a new request waits
        a = 16'h00FF; b = 16'h0001; ci = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0001; b = 16'h0001;
        for (int i = 0; i < 4; i++) tick();
        check("bp_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_s", 32'(s), 32'h0100);
            check("bp_co", 32'(co), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
        tick();
        in_valid = 1'b0;
        check("bp_new_accepted", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_s", 32'(s), 32'h0002);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset on the second RUN cycle aborts the operation
        a = 16'h1111; b = 16'h2222; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s", 32'(s), 32'h0);
        check("abort_co", 32'(co), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end

        // Reset wins over a simultaneous request
        rst = 1'b1; in_valid = 1'b1; a = 16'h0003; b = 16'h0004;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_vs_valid_busy", 32'(busy), 32'd0);

`ifdef ADD_SEQ_SUB_EN
        run_op("sub_borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_no_borrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        run_op("sub_off_add",   16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
